retire_rob: RTL and testbench

In-order retirement buffer that sits downstream of the rename stage. It is the consumer end of the rename free-list return path. Each dispatched (renamed) instruction is recorded with its destination mapping. Completions from execution are tracked out of order. Entries retire strictly in program order, and each retirement drives retire_valid / retire_phys_reg back to rename so the superseded physical register re-enters the free list.

---
 rtl/rob_pkg.sv | 25 ++
 rtl/rob_ptr_ctrl.sv | 55 +++++
 rtl/retire_rob.sv | 123 ++++++++++++
 tb/tb_retire_rob.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared types and sizes for the retirement buffer.
// Rename uses the same ARCH_W / PHYS_W.
package rob_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int TAG_W     = 4;
  localparam int ARCH_W    = 5;
  localparam int PHYS_W    = 6;
  localparam int PTR_W     = TAG_W + 1;

  typedef logic [TAG_W-1:0]  rob_tag_t;
  typedef logic [PTR_W-1:0]  rob_ptr_t;
  typedef logic [ARCH_W-1:0] arch_reg_t;
  typedef logic [PHYS_W-1:0] phys_reg_t;

  typedef struct packed {
    logic      valid;
    logic      done;
    logic      has_rd;
    arch_reg_t rd;
    phys_reg_t phys_rd;
    phys_reg_t old_phys_rd;
  } rob_entry_t;

endpackage

// File: rtl/rob_ptr_ctrl.sv
// Head/tail pointers with wrap bit, occupancy flags and count.
// Flush and reset both return the pointers to zero.
module rob_ptr_ctrl
  import rob_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push_req,
  input  logic             pop,
  output logic             push,
  output rob_tag_t         head_idx,
  output rob_tag_t         tail_idx,
  output logic             full,
  output logic             empty,
  output logic [TAG_W:0]   count
);

  rob_ptr_t head_q, head_d;
  rob_ptr_t tail_q, tail_d;

  assign head_idx = head_q[TAG_W-1:0];
  assign tail_idx = tail_q[TAG_W-1:0];

  assign empty = (head_q == tail_q);
  assign full  = (head_idx == tail_idx) &&
                 (head_q[TAG_W] != tail_q[TAG_W]);
  assign count = tail_q - head_q;

  // Acceptance uses pre-edge fullness; a same-cycle pop does not help.
  assign push = push_req && !full;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      if (push) tail_d = tail_q + rob_ptr_t'(1);
      if (pop)  head_d = head_q + rob_ptr_t'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

endmodule

// File: rtl/retire_rob.sv
// In-order retirement buffer; returns superseded physical
// registers to the rename free list one per cycle.
module retire_rob
  import rob_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              dispatch_valid,
  output logic              dispatch_ready,
  input  logic              dispatch_has_rd,
  input  logic [ARCH_W-1:0] dispatch_rd,
  input  logic [PHYS_W-1:0] dispatch_phys_rd,
  input  logic [PHYS_W-1:0] dispatch_old_phys_rd,
  output logic [TAG_W-1:0]  dispatch_tag,
  input  logic              complete_valid,
  input  logic [TAG_W-1:0]  complete_tag,
  input  logic              flush,
  output logic              retire_valid,
  output logic [PHYS_W-1:0] retire_phys_reg,
  output logic [ARCH_W-1:0] retire_arch_rd,
  output logic [PHYS_W-1:0] retire_new_phys,
  output logic              rob_empty,
  output logic              rob_full,
  output logic [TAG_W:0]    rob_count
);

  rob_entry_t entries_q [ROB_DEPTH];
  rob_entry_t entries_d [ROB_DEPTH];
  rob_entry_t head_e;

  rob_tag_t  head_idx;
  rob_tag_t  tail_idx;
  logic      push;
  logic      pop;

  logic      rv_q, rv_d;
  phys_reg_t rphys_q, rphys_d;
  arch_reg_t rarch_q, rarch_d;
  phys_reg_t rnew_q, rnew_d;

  assign head_e = entries_q[head_idx];
  assign pop    = head_e.valid && head_e.done;

  rob_ptr_ctrl u_ptr (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (flush),
    .push_req (dispatch_valid),
    .pop      (pop),
    .push     (push),
    .head_idx (head_idx),
    .tail_idx (tail_idx),
    .full     (rob_full),
    .empty    (rob_empty),
    .count    (rob_count)
  );

  assign dispatch_ready  = !rob_full;
  assign dispatch_tag    = tail_idx;
  assign retire_valid    = rv_q;
  assign retire_phys_reg = rphys_q;
  assign retire_arch_rd  = rarch_q;
  assign retire_new_phys = rnew_q;

  always_comb begin
    entries_d = entries_q;
    rv_d      = 1'b0;
    rphys_d   = rphys_q;
    rarch_d   = rarch_q;
    rnew_d    = rnew_q;
    if (flush) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        entries_d[i] = '0;
      end
    end else begin
      if (complete_valid && entries_q[complete_tag].valid &&
          !(push && complete_tag == tail_idx)) begin
        entries_d[complete_tag].done = 1'b1;
      end
      // Fields only move on a visible retire so they hold otherwise.
      if (pop) begin
        entries_d[head_idx] = '0;
        rv_d = head_e.has_rd;
        if (head_e.has_rd) begin
          rphys_d = head_e.old_phys_rd;
          rarch_d = head_e.rd;
          rnew_d  = head_e.phys_rd;
        end
      end
      if (push) begin
        entries_d[tail_idx] = '{
          valid:       1'b1,
          done:        1'b0,
          has_rd:      dispatch_has_rd,
          rd:          dispatch_rd,
          phys_rd:     dispatch_phys_rd,
          old_phys_rd: dispatch_old_phys_rd
        };
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      rv_q    <= 1'b0;
      rphys_q <= '0;
      rarch_q <= '0;
      rnew_q  <= '0;
    end else begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        entries_q[i] <= entries_d[i];
      end
      rv_q    <= rv_d;
      rphys_q <= rphys_d;
      rarch_q <= rarch_d;
      rnew_q  <= rnew_d;
    end
  end

endmodule

// File: tb/tb_retire_rob.sv
// Scoreboard bench for retire_rob: expected retirements are
// queued at dispatch and matched against retire pulses.
module tb_retire_rob;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       dispatch_valid;
  logic       dispatch_ready;
  logic       dispatch_has_rd;
  logic [4:0] dispatch_rd;
  logic [5:0] dispatch_phys_rd;
  logic [5:0] dispatch_old_phys_rd;
  logic [3:0] dispatch_tag;
  logic       complete_valid;
  logic [3:0] complete_tag;
  logic       flush;
  logic       retire_valid;
  logic [5:0] retire_phys_reg;
  logic [4:0] retire_arch_rd;
  logic [5:0] retire_new_phys;
  logic       rob_empty;
  logic       rob_full;
  logic [4:0] rob_count;

  typedef struct {
    logic [5:0] old_p;
    logic [4:0] rd;
    logic [5:0] new_p;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   retire_cnt = 0;

  always #5 clk = ~clk;

  retire_rob dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .dispatch_valid       (dispatch_valid),
    .dispatch_ready       (dispatch_ready),
    .dispatch_has_rd      (dispatch_has_rd),
    .dispatch_rd          (dispatch_rd),
    .dispatch_phys_rd     (dispatch_phys_rd),
    .dispatch_old_phys_rd (dispatch_old_phys_rd),
    .dispatch_tag         (dispatch_tag),
    .complete_valid       (complete_valid),
    .complete_tag         (complete_tag),
    .flush                (flush),
    .retire_valid         (retire_valid),
    .retire_phys_reg      (retire_phys_reg),
    .retire_arch_rd       (retire_arch_rd),
    .retire_new_phys      (retire_new_phys),
    .rob_empty            (rob_empty),
    .rob_full             (rob_full),
    .rob_count            (rob_count)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1 && retire_valid === 1'b1) begin
      retire_cnt++;
      if (sb.size() == 0) begin
        check("spurious_retire", retire_valid, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ret_old", retire_phys_reg, e.old_p);
        check("ret_rd", retire_arch_rd, e.rd);
        check("ret_new", retire_new_phys, e.new_p);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    dispatch_valid = 1'b0;
    dispatch_has_rd = 1'b0;
    dispatch_rd = '0;
    dispatch_phys_rd = '0;
    dispatch_old_phys_rd = '0;
    complete_valid = 1'b0;
    complete_tag = '0;
    flush = 1'b0;
    sb.delete();
    step();
    step();
    check("rst_empty", rob_empty, 1);
    check("rst_count", rob_count, 0);
    check("rst_rv", retire_valid, 0);
    reset_n = 1'b1;
  endtask

  task automatic dispatch(input logic hr, input int rd,
                          input int p, input int o,
                          input int exp_tag, input logic acc);
    exp_t e;
    dispatch_valid = 1'b1;
    dispatch_has_rd = hr;
    dispatch_rd = 5'(rd);
    dispatch_phys_rd = 6'(p);
    dispatch_old_phys_rd = 6'(o);
    check("dtag", dispatch_tag, exp_tag);
    check("dready", dispatch_ready, acc);
    if (acc && hr) begin
      e.old_p = 6'(o);
      e.rd = 5'(rd);
      e.new_p = 6'(p);
      sb.push_back(e);
    end
    step();
    dispatch_valid = 1'b0;
  endtask

  task automatic complete(input int tag);
    complete_valid = 1'b1;
    complete_tag = 4'(tag);
    step();
    complete_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (rob_count != 0 && n < 50) begin
      step();
      n++;
    end
    check("drain", rob_count, 0);
    step();
    check("sb_empty", sb.size(), 0);
  endtask

  initial begin
    int r0;

    // reset state
    do_reset();
    check("ready_post", dispatch_ready, 1);
    check("tag_post", dispatch_tag, 0);
    check("full_post", rob_full, 0);
    step();
    check("rv_idle", retire_valid, 0);

    // out-of-order completion, in-order retire
    dispatch(1, 1, 32, 1, 0, 1);
    dispatch(1, 2, 33, 2, 1, 1);
    dispatch(1, 3, 34, 3, 2, 1);
    check("cnt3", rob_count, 3);
    complete(2);
    check("no_rv_early", retire_valid, 0);
    complete(0);
    check("no_rv_yet", retire_valid, 0);
    complete(1);
    check("lat_rv", retire_valid, 1);
    check("lat_phys", retire_phys_reg, 1);
    step();
    check("b2b_phys2", retire_phys_reg, 2);
    step();
    check("b2b_phys3", retire_phys_reg, 3);
    wait_empty();

    // fill, overflow attempt, wrap
    do_reset();
    for (int i = 0; i < 16; i++) begin
      dispatch(1, i + 1, 16 + i, 40 + i, i, 1);
    end
    check("full", rob_full, 1);
    check("full_cnt", rob_count, 16);
    dispatch(1, 9, 9, 9, 0, 0);
    check("ovf_cnt", rob_count, 16);
    complete(0);
    step();
    check("one_ret_cnt", rob_count, 15);
    check("one_ret_rv", retire_valid, 1);
    check("one_ret_phys", retire_phys_reg, 40);
    dispatch(1, 9, 9, 9, 0, 1);
    check("wrap_cnt", rob_count, 16);

    // silent retire for has_rd=0
    do_reset();
    r0 = retire_cnt;
    dispatch(0, 7, 20, 21, 0, 1);
    dispatch(1, 8, 22, 5, 1, 1);
    complete(0);
    complete(1);
    step();
    step();
    step();
    check("silent_pulses", retire_cnt - r0, 1);
    check("silent_cnt", rob_count, 0);
    check("silent_sb", sb.size(), 0);

    // flush beats dispatch and complete
    do_reset();
    for (int i = 0; i < 5; i++) begin
      dispatch(1, i + 1, 10 + i, 20 + i, i, 1);
    end
    check("pre_flush_cnt", rob_count, 5);
    flush = 1'b1;
    complete_valid = 1'b1;
    complete_tag = 4'd0;
    dispatch_valid = 1'b1;
    sb.delete();
    step();
    flush = 1'b0;
    complete_valid = 1'b0;
    dispatch_valid = 1'b0;
    check("flush_cnt", rob_count, 0);
    check("flush_empty", rob_empty, 1);
    check("flush_rv", retire_valid, 0);
    step();
    check("flush_rv2", retire_valid, 0);
    dispatch(1, 4, 4, 4, 0, 1);

    // asynchronous reset mid-operation
    do_reset();
    for (int i = 0; i < 8; i++) begin
      dispatch(1, i + 1, 30 + i, 50 + i, i, 1);
    end
    complete(0);
    step();
    check("mid_cnt7", rob_count, 7);
    check("mid_rv1", retire_valid, 1);
    #1;
    reset_n = 1'b0;
    sb.delete();
    #1;
    check("async_rv", retire_valid, 0);
    check("async_cnt", rob_count, 0);
    check("async_empty", rob_empty, 1);
    check("async_ready", dispatch_ready, 1);
    step();
    reset_n = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
